// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes and sequencer state encoding
package alu_pkg;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_XNOR  = 3'b101;
    localparam logic [2:0] ALU_ZERO0 = 3'b110;
    localparam logic [2:0] ALU_ZERO1 = 3'b111;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_EXEC = 2'd1,
        SEQ_RESP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 8-bit ALU driven by the command sequencer
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    input  logic [2:0]       sel,
    input  logic             cin,
    output logic [WIDTH-1:0] alu_out,
    output logic             overflow_flag,
    output logic             zero_flag
);

    logic [WIDTH:0] wide;

    // overflow_flag is the unsigned carry-out for ADD and the borrow for SUB
    always_comb begin
        wide          = '0;
        overflow_flag = 1'b0;
        case (sel)
            ALU_ADD: begin
                wide          = {1'b0, input_1} + {1'b0, input_2} + {{WIDTH{1'b0}}, cin};
                overflow_flag = wide[WIDTH];
            end
            ALU_SUB: begin
                wide          = {1'b0, input_1} - {1'b0, input_2};
                overflow_flag = wide[WIDTH];
            end
            ALU_AND:  wide = {1'b0, input_1 & input_2};
            ALU_OR:   wide = {1'b0, input_1 | input_2};
            ALU_XOR:  wide = {1'b0, input_1 ^ input_2};
            ALU_XNOR: wide = {1'b0, ~(input_1 ^ input_2)};
            default:  wide = '0;
        endcase
    end

    assign alu_out   = wide[WIDTH-1:0];
    assign zero_flag = (alu_out == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - valid/ready command front-end for the combinational ALU
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [SEL_W-1:0] cmd_sel,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_cin,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] alu_input_1,
    output logic [WIDTH-1:0] alu_input_2,
    output logic [SEL_W-1:0] alu_sel,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_ovf,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_ovf,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] op_count,
    output logic             ovf_sticky,
    input  logic             sticky_clr
);

    seq_state_t state;
    logic       accept;

    // In RESP a new command is only taken together with the outgoing response
    assign cmd_ready = (state == SEQ_IDLE) || ((state == SEQ_RESP) && rsp_ready);
    assign rsp_valid = (state == SEQ_RESP);
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEQ_IDLE;
            alu_input_1 <= '0;
            alu_input_2 <= '0;
            alu_sel     <= '0;
            alu_cin     <= 1'b0;
            rsp_data    <= '0;
            rsp_ovf     <= 1'b0;
            rsp_zero    <= 1'b0;
            acc         <= '0;
            op_count    <= '0;
            ovf_sticky  <= 1'b0;
        end else begin
            if (sticky_clr) begin
                ovf_sticky <= 1'b0;
            end

            // acc here is the value at acceptance, i.e. the result being returned in RESP
            if (accept) begin
                alu_input_1 <= cmd_use_acc ? acc : cmd_a;
                alu_input_2 <= cmd_b;
                alu_sel     <= cmd_sel;
                alu_cin     <= (cmd_sel == SEL_W'(ALU_ADD)) && cmd_cin;
            end

            case (state)
                SEQ_IDLE: begin
                    if (accept) begin
                        state <= SEQ_EXEC;
                    end
                end
                SEQ_EXEC: begin
                    rsp_data <= alu_result;
                    rsp_ovf  <= alu_ovf;
                    rsp_zero <= alu_zero;
                    acc      <= alu_result;
                    if (op_count != {CNT_W{1'b1}}) begin
                        op_count <= op_count + 1'b1;
                    end
                    if (!sticky_clr && alu_ovf) begin
                        ovf_sticky <= 1'b1;
                    end
                    state <= SEQ_RESP;
                end
                SEQ_RESP: begin
                    if (rsp_ready) begin
                        state <= accept ? SEQ_EXEC : SEQ_IDLE;
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed scoreboard bench for alu_cmd_sequencer with the real alu
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_sel;
    logic [7:0]  cmd_a, cmd_b;
    logic        cmd_cin, cmd_use_acc;
    logic [7:0]  alu_input_1, alu_input_2;
    logic [2:0]  alu_sel;
    logic        alu_cin;
    logic [7:0]  alu_result;
    logic        alu_ovf, alu_zero;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_ovf, rsp_zero;
    logic [7:0]  acc;
    logic [15:0] op_count;
    logic        ovf_sticky, sticky_clr;

    int total = 0;
    int bad   = 0;
    logic [9:0] exp_q[$];
    logic [7:0] tb_acc;
    logic [9:0] e;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(8), .SEL_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_use_acc(cmd_use_acc),
        .alu_input_1(alu_input_1), .alu_input_2(alu_input_2), .alu_sel(alu_sel),
        .alu_cin(alu_cin), .alu_result(alu_result), .alu_ovf(alu_ovf), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero), .acc(acc), .op_count(op_count),
        .ovf_sticky(ovf_sticky), .sticky_clr(sticky_clr)
    );

    alu #(.WIDTH(8)) u_alu (
        .input_1(alu_input_1), .input_2(alu_input_2), .sel(alu_sel), .cin(alu_cin),
        .alu_out(alu_result), .overflow_flag(alu_ovf), .zero_flag(alu_zero)
    );

    // expected {ovf, zero, data}
    function automatic logic [9:0] model(input logic [2:0] sel, input logic [7:0] a, b,
                                         input logic cin);
        logic [7:0] d;
        logic       o;
        o = 1'b0;
        case (sel)
            3'b000:  {o, d} = 9'(a) + 9'(b) + 9'(cin);
            3'b001:  begin d = a - b; o = (a < b); end
            3'b010:  d = a & b;
            3'b011:  d = a | b;
            3'b100:  d = a ^ b;
            3'b101:  d = ~(a ^ b);
            default: d = 8'h00;
        endcase
        return {o, (d == 8'h00), d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] sel, input logic [7:0] a, b,
                         input logic cin, use_acc);
        exp_q.push_back(model(sel, use_acc ? tb_acc : a, b, cin));
        cmd_sel = sel; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_use_acc = use_acc;
        cmd_valid = 1'b1;
        #1;
        for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) @(negedge clk);
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) @(negedge clk);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic pop_cmp(input string tag);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_nonempty"}, 32'd0, 32'd1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        chk({tag, "_data"}, 32'(rsp_data), 32'(e[7:0]));
        chk({tag, "_zero"}, 32'(rsp_zero), 32'(e[8]));
        chk({tag, "_ovf"}, 32'(rsp_ovf), 32'(e[9]));
        tb_acc = e[7:0];
    endtask

    task automatic collect(input string tag);
        wait_rsp(tag);
        pop_cmp(tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_acc"}, 32'(acc), 32'(tb_acc));
        chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_sel = '0; cmd_a = '0; cmd_b = '0;
        cmd_cin = 1'b0; cmd_use_acc = 1'b0; rsp_ready = 1'b0; sticky_clr = 1'b0;
        tb_acc = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_acc", 32'(acc), 32'd0);
        chk("reset_op_count", 32'(op_count), 32'd0);
        chk("reset_sticky", 32'(ovf_sticky), 32'd0);

        // 1: ADD latency, response valid after the second edge counted from acceptance
        issue(ALU_ADD, 8'h01, 8'h01, 1'b0, 1'b0);
        chk("t1_not_yet_valid", 32'(rsp_valid), 32'd0);
        chk("t1_busy", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("t1_valid_at_2", 32'(rsp_valid), 32'd1);
        collect("t1");
        chk("t1_op_count", 32'(op_count), 32'd1);

        // 2: SUB borrow, sticky set, sticky_clr priority, SUB to zero
        issue(ALU_SUB, 8'h00, 8'h01, 1'b0, 1'b0);
        collect("t2a");
        chk("t2a_sticky", 32'(ovf_sticky), 32'd1);
        issue(ALU_SUB, 8'h00, 8'h01, 1'b0, 1'b0);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        chk("t2b_clr_priority", 32'(ovf_sticky), 32'd0);
        collect("t2b");
        issue(ALU_SUB, 8'hFF, 8'hFF, 1'b0, 1'b0);
        collect("t2c");
        chk("t2c_sticky_stays_clear", 32'(ovf_sticky), 32'd0);

        // 3: back-to-back accept in RESP with use_acc
        issue(ALU_ADD, 8'h55, 8'h33, 1'b0, 1'b0);
        wait_rsp("t3a");
        pop_cmp("t3a");
        exp_q.push_back(model(ALU_AND, tb_acc, 8'h0F, 1'b0));
        cmd_sel = ALU_AND; cmd_a = 8'hFF; cmd_b = 8'h0F; cmd_cin = 1'b0; cmd_use_acc = 1'b1;
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        chk("t3_ready_in_resp", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        chk("t3_exec_no_valid", 32'(rsp_valid), 32'd0);
        chk("t3_operand_from_acc", 32'(alu_input_1), 32'h88);
        collect("t3b");

        // 4: response held under backpressure, no command accepted
        issue(ALU_XOR, 8'hCC, 8'hAA, 1'b0, 1'b0);
        wait_rsp("t4");
        cmd_sel = ALU_OR; cmd_a = 8'h01; cmd_b = 8'h02; cmd_valid = 1'b1; cmd_use_acc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_data", 32'(rsp_data), 32'h66);
            chk("t4_hold_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        collect("t4");

        // 5: reserved opcode passes through, carry-in masked
        issue(ALU_ZERO0, 8'hCC, 8'hAA, 1'b1, 1'b0);
        chk("t5_cin_masked", 32'(alu_cin), 32'd0);
        chk("t5_sel_passed", 32'(alu_sel), 32'd6);
        collect("t5");
        chk("pre_reset_op_count", 32'(op_count), 32'd8);

        // 6: asynchronous reset during EXEC discards the operation
        issue(ALU_ADD, 8'h01, 8'h02, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_alu_in1", 32'(alu_input_1), 32'd0);
        chk("t6_alu_sel", 32'(alu_sel), 32'd0);
        chk("t6_rsp_data", 32'(rsp_data), 32'd0);
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t6_acc", 32'(acc), 32'd0);
        chk("t6_op_count", 32'(op_count), 32'd0);
        chk("t6_sticky", 32'(ovf_sticky), 32'd0);
        void'(exp_q.pop_back());
        tb_acc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_no_response", 32'(rsp_valid), 32'd0);
        issue(ALU_ADD, 8'hAB, 8'h10, 1'b0, 1'b1);
        collect("t6_after");
        chk("t6_after_op_count", 32'(op_count), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
